fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I fetch front end: owns the fetch PC, issues in-order instruction reads and queues PC-tagged words for decode.
// Build option: define FETCH_PREDICT_EN to predecode the head with BTFNT and redirect fetch on predicted-taken pops.

package memory_io_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  do_read;
        logic [3:0]  do_write;
        logic [31:0] data;
    } memory_io_req;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } memory_io_rsp;
endpackage

module fetch_unit
    import memory_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  reset_pc,
    output memory_io_req inst_mem_req,
    input  memory_io_rsp inst_mem_rsp,
    output logic         out_valid,
    output logic [31:0]  out_instr,
    output logic [31:0]  out_pc,
    output logic         out_pred_taken,
    input  logic         out_ready,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_W = DEPTH[PW+1:0];

    typedef logic [PW:0] ptr_t;

    logic [31:0]      slot_pc    [DEPTH];
    logic [31:0]      slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_filled;

    ptr_t        alloc_ptr;
    ptr_t        fill_ptr;
    ptr_t        read_ptr;
    ptr_t        drop_count;
    logic [31:0] fetch_pc;

    ptr_t          reserved_count;
    ptr_t          unfilled_count;
    logic [PW+1:0] budget;
    logic [PW-1:0] read_idx;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] alloc_idx;
    logic          issue;
    logic          pop;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          flush;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic [31:0]   flush_pc;

    assign read_idx  = read_ptr[PW-1:0];
    assign fill_idx  = fill_ptr[PW-1:0];
    assign alloc_idx = alloc_ptr[PW-1:0];

    assign reserved_count = alloc_ptr - read_ptr;
    assign unfilled_count = alloc_ptr - fill_ptr;
    assign budget         = {1'b0, reserved_count} + {1'b0, drop_count};

    assign out_valid = slot_filled[read_idx];
    assign out_instr = slot_instr[read_idx];
    assign out_pc    = slot_pc[read_idx];
    assign pop       = out_valid && out_ready;

`ifdef FETCH_PREDICT_EN
    logic [6:0]  opcode;
    logic        is_jal;
    logic        is_branch;
    logic [31:0] imm_j;
    logic [31:0] imm_b;

    assign opcode    = out_instr[6:0];
    assign is_jal    = (opcode == 7'b1101111);
    assign is_branch = (opcode == 7'b1100011);
    assign imm_j = {{12{out_instr[31]}}, out_instr[19:12], out_instr[20], out_instr[30:21], 1'b0};
    assign imm_b = {{20{out_instr[31]}}, out_instr[7], out_instr[30:25], out_instr[11:8], 1'b0};

    // Backward branches (negative offset) and all JALs are predicted taken.
    assign pred_taken  = out_valid && (is_jal || (is_branch && out_instr[31]));
    assign pred_target = out_pc + (is_jal ? imm_j : imm_b);
`else
    assign pred_taken  = 1'b0;
    assign pred_target = 32'h0;
`endif

    assign out_pred_taken = pred_taken;

    // External redirect wins over the internal predicted-taken redirect.
    assign flush    = redirect_valid || (pop && pred_taken);
    assign flush_pc = redirect_valid ? (redirect_pc & ~32'h3) : (pred_target & ~32'h3);

    assign issue    = reset && !flush && (budget < DEPTH_W);
    assign rsp_drop = inst_mem_rsp.valid && (drop_count != '0);
    assign rsp_fill = inst_mem_rsp.valid && (drop_count == '0) && (unfilled_count != '0);

    always_comb begin
        inst_mem_req         = '0;
        inst_mem_req.valid   = issue;
        inst_mem_req.addr    = fetch_pc;
        inst_mem_req.do_read = issue ? 4'b1111 : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= reset_pc;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            read_ptr    <= '0;
            drop_count  <= '0;
            slot_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_instr[i] <= '0;
            end
        end else if (flush) begin
            // Everything still in flight, minus a response landing this cycle, must be discarded later.
            fetch_pc    <= flush_pc;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            read_ptr    <= '0;
            slot_filled <= '0;
            drop_count  <= drop_count + unfilled_count - ptr_t'(rsp_drop || rsp_fill);
        end else begin
            if (rsp_drop) begin
                drop_count <= drop_count - ptr_t'(1);
            end
            if (rsp_fill) begin
                slot_instr[fill_idx]  <= inst_mem_rsp.data;
                slot_filled[fill_idx] <= 1'b1;
                fill_ptr              <= fill_ptr + ptr_t'(1);
            end
            if (pop) begin
                slot_filled[read_idx] <= 1'b0;
                read_ptr              <= read_ptr + ptr_t'(1);
            end
            if (issue) begin
                slot_pc[alloc_idx] <= fetch_pc;
                alloc_ptr          <= alloc_ptr + ptr_t'(1);
                fetch_pc           <= fetch_pc + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-configurable in-order memory model, delivery log and hand-computed PCs.
module tb_fetch_unit;
    import memory_io_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  reset_pc = 32'h100;
    memory_io_req inst_mem_req;
    memory_io_rsp inst_mem_rsp;
    logic         out_valid;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc;
    logic         out_pred_taken;
    logic         out_ready = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_pc = 32'h0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mem_lat = 1;
    logic        jal_at_100 = 1'b0;
    logic [31:0] reqq[$];
    logic [31:0] deliv[$];
    logic        pv[4];
    logic [31:0] pa[4];

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .reset_pc       (reset_pc),
        .inst_mem_req   (inst_mem_req),
        .inst_mem_rsp   (inst_mem_rsp),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_at_100 && a == 32'h100) return 32'hFF9FF06F;  // jal x0, -8
        return {a[24:0], 7'h13};
    endfunction

    // Fixed-latency in-order memory, cleared with the core.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= inst_mem_req.valid;
            pa[0] <= inst_mem_req.addr;
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    always_comb begin
        inst_mem_rsp       = '0;
        inst_mem_rsp.valid = pv[mem_lat-1];
        inst_mem_rsp.data  = mem_word(pa[mem_lat-1]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_deliv(input string tag, input int idx, input logic [31:0] exp);
        if (idx < deliv.size()) check(tag, deliv[idx], exp);
        else check({tag, "_count"}, 32'(deliv.size()), 32'(idx + 1));
    endtask

    task automatic check_req(input string tag, input int idx, input logic [31:0] exp);
        if (idx < reqq.size()) check(tag, reqq[idx], exp);
        else check({tag, "_count"}, 32'(reqq.size()), 32'(idx + 1));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (inst_mem_req.valid) reqq.push_back(inst_mem_req.addr);
            if (out_valid && out_ready && !redirect_valid) begin
                deliv.push_back(out_pc);
                check("deliv_instr", out_instr, mem_word(out_pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the posedge that opens cycle 0 with reset released.
    task automatic start(input int lat, input logic rdy);
        tick();
        reset          = 1'b0;
        mem_lat        = lat;
        out_ready      = rdy;
        redirect_valid = 1'b0;
        jal_at_100     = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_req_valid", 32'(inst_mem_req.valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_pred", 32'(out_pred_taken), 32'd0);
        reqq.delete();
        deliv.delete();
        tick();
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            tick();
        end
    endtask

    initial begin
        int stale;

        // Streaming at L=1.
        start(1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t1_req_valid", 32'(inst_mem_req.valid), 32'd1);
            check("t1_req_addr", inst_mem_req.addr, 32'h100 + 32'(4 * c));
            if (c == 0) begin
                check("t1_do_read", 32'(inst_mem_req.do_read), 32'hF);
                check("t1_do_write", 32'(inst_mem_req.do_write), 32'h0);
            end
            check("t1_out_valid", 32'(out_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) check("t1_out_pc", out_pc, 32'h100 + 32'(4 * (c - 2)));
            tick();
        end

        // Stall fills the queue, then drains in order.
        start(1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check("t2_hold_valid", 32'(out_valid), 32'd1);
                check("t2_hold_pc", out_pc, 32'h100);
                check("t2_hold_instr", out_instr, mem_word(32'h100));
            end
            tick();
        end
        check("t2_req_count", 32'(reqq.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_req("t2_req_addr", i, 32'h100 + 32'(4 * i));
        out_ready = 1'b1;
        run(6);
        for (int i = 0; i < 5; i++) check_deliv("t2_drain", i, 32'h100 + 32'(4 * i));
        check_req("t2_resume", 4, 32'h110);

        // Redirect with two responses in flight at L=3.
        start(3, 1'b1);
        run(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("t3_no_issue", 32'(inst_mem_req.valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        for (int c = 3; c < 13; c++) begin
            @(negedge clk);
            if (c == 6) check("t3_not_yet", 32'(out_valid), 32'd0);
            if (c == 7) begin
                check("t3_valid_lat", 32'(out_valid), 32'd1);
                check("t3_pc_lat", out_pc, 32'h200);
            end
            tick();
        end
        check_req("t3_req_new", 2, 32'h200);
        check_deliv("t3_first", 0, 32'h200);
        check_deliv("t3_second", 1, 32'h204);
        stale = 0;
        foreach (deliv[i]) if (deliv[i] < 32'h200) stale++;
        check("t3_stale", 32'(stale), 32'd0);

        // Redirect coincident with a pop of 0x104.
        start(1, 1'b1);
        run(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("t4_pop_valid", 32'(out_valid), 32'd1);
        check("t4_pop_pc", out_pc, 32'h104);
        tick();
        redirect_valid = 1'b0;
        run(5);
        check_deliv("t4_d0", 0, 32'h100);
        check_deliv("t4_d1", 1, 32'h200);
        check_req("t4_req_new", 3, 32'h200);

        // Misaligned redirect target.
        start(1, 1'b1);
        run(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        check("t5_no_issue", 32'(inst_mem_req.valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_req_valid", 32'(inst_mem_req.valid), 32'd1);
        check("t5_req_addr", inst_mem_req.addr, 32'h200);
        tick();
        run(4);
        check_deliv("t5_first", 0, 32'h200);

        // JAL -8 at 0x100.
        start(1, 1'b1);
        jal_at_100 = 1'b1;
        run(2);
        @(negedge clk);
        check("t6_head_pc", out_pc, 32'h100);
`ifdef FETCH_PREDICT_EN
        check("t6_pred", 32'(out_pred_taken), 32'd1);
`else
        check("t6_pred", 32'(out_pred_taken), 32'd0);
`endif
        tick();
        run(6);
        check_deliv("t6_d0", 0, 32'h100);
`ifdef FETCH_PREDICT_EN
        check_deliv("t6_d1", 1, 32'h0F8);
        check_req("t6_req_target", 2, 32'h0F8);
`else
        check_deliv("t6_d1", 1, 32'h104);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
